// File: rtl/coriolis_stream_source_if.sv
// Kernel-facing input stream of the coriolis source: four data lanes with
// lockstep valids and the kernel's aggregated ready.
interface coriolis_stream_source_if #(
  parameter int STREAMW = 34
);
  logic [STREAMW-1:0] x;
  logic [STREAMW-1:0] v;
  logic [STREAMW-1:0] y;
  logic [STREAMW-1:0] u;
  logic               ivalid_x;
  logic               ivalid_v;
  logic               ivalid_y;
  logic               ivalid_u;
  logic               iready;

  modport master (
    output x, v, y, u,
    output ivalid_x, ivalid_v, ivalid_y, ivalid_u,
    input  iready
  );

  modport slave (
    input  x, v, y, u,
    input  ivalid_x, ivalid_v, ivalid_y, ivalid_u,
    output iready
  );
endinterface

// File: rtl/coriolis_stream_source.sv
// Four-lane lockstep stream transmitter: host fills per-lane FWFT FIFOs,
// a start pulse issues exactly nitems beats to the coriolis kernel.
module coriolis_stream_source #(
  parameter int STREAMW  = 34,
  parameter int DEPTH    = 16,
  parameter int NITEMS_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [1:0]          wr_lane,
  input  logic [STREAMW-1:0]  wr_data,
  output logic [3:0]          wr_full,
  input  logic                start,
  input  logic [NITEMS_W-1:0] nitems,
  output logic                busy,
  output logic                done,
  output logic                err_ovf,
  output logic [NITEMS_W-1:0] sent_count,
  coriolis_stream_source_if.master strm
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_next;

  logic [STREAMW-1:0]  mem [4][DEPTH];
  logic [PW-1:0]       rd_ptr [4];
  logic [PW-1:0]       wr_ptr [4];
  logic [CW-1:0]       count  [4];
  logic [3:0]          push;
  logic [3:0]          nonempty;
  logic [3:0]          full;
  logic                all_ready;
  logic                beat;
  logic                last_beat;
  logic [NITEMS_W-1:0] nitems_q;

  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nonempty[i] = (count[i] != '0);
      full[i]     = (count[i] == CW'(DEPTH));
      push[i]     = wr_en && (wr_lane == 2'(i)) && !full[i];
    end
  end

  assign all_ready = &nonempty;
  assign beat      = (state == S_RUN) && all_ready && strm.iready;
  assign last_beat = beat && ((sent_count + NITEMS_W'(1)) == nitems_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      err_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (beat)    rd_ptr[i] <= rd_ptr[i] + PW'(1);
        case ({push[i], beat})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
      // Fullness is judged before this cycle's pop, so a write to a full lane is lost.
      if (wr_en && full[wr_lane]) err_ovf <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the emptied pointers/counts make stale words unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = (nitems != '0) ? S_RUN : S_DONE;
      S_RUN:  if (last_beat) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_count <= '0;
      nitems_q   <= '0;
    end else if (state == S_IDLE && start) begin
      sent_count <= '0;
      nitems_q   <= nitems;
    end else if (beat) begin
      sent_count <= sent_count + NITEMS_W'(1);
    end
  end

  assign busy    = (state == S_RUN);
  assign done    = (state == S_DONE);
  assign wr_full = full;

  // Valid is a function of state and emptiness only, never of iready.
  assign strm.ivalid_x = busy && all_ready;
  assign strm.ivalid_v = busy && all_ready;
  assign strm.ivalid_y = busy && all_ready;
  assign strm.ivalid_u = busy && all_ready;

  assign strm.x = mem[0][rd_ptr[0]];
  assign strm.v = mem[1][rd_ptr[1]];
  assign strm.y = mem[2][rd_ptr[2]];
  assign strm.u = mem[3][rd_ptr[3]];

endmodule
